snoop_bus_arbiter: RTL and testbench
====================================

Name: snoop_bus_arbiter

Overview:
- Two-master bus controller between cache A / cache B and the shared main memory.
- Arbitrates read/write requests and latches the winner's command.
- Drives the memory's AR / RW_A / RW_B / snoop_A / snoop_B / addr / data inputs, so the non-owning cache is marked as snooper.
- Waits for DR and returns read data plus a done pulse to the owning master; a timeout guards against a memory that never answers.

Parameters:
- ADDR_W, 24, request/memory address width (upper 16 = tag, lower 8 = line index)
- DATA_W, 32, data width
- TIMEOUT, 15, max WAIT cycles before abort (4-bit counter, must be 1..15)

Ports:
- SCLK  in  1  clock
- SRST  in  1  reset
- req_a  in  1  cache A request, held until done_a
- rw_a  in  1  A: 1=read, 0=write
- addr_a  in  ADDR_W  A address
- wdata_a  in  DATA_W  A write data
- req_b, rw_b, addr_b, wdata_b  in  1/1/ADDR_W/DATA_W  same for cache B
- gnt_a, gnt_b  out  1  owner flag, high from REQ through DONE
- done_a, done_b  out  1  one-cycle completion pulse
- rdata  out  DATA_W  read data, valid with done_x on reads
- err  out  1  one-cycle pulse with done_x on timeout
- mem_ar  out  1  access request to memory
- mem_rw_a, mem_rw_b  out  1  read/write flag for the owning side
- mem_snoop_a, mem_snoop_b  out  1  snooper select (the non-owner)
- mem_addr  out  ADDR_W  latched address
- mem_wdata  out  DATA_W  latched write data
- mem_rdata  in  DATA_W  memory read data
- mem_dr  in  1  memory data ready

Behaviour:
- Reset is SRST, synchronous, active-high; clock is SCLK.
- Reset state:
  - All outputs 0 and FSM in IDLE.
  - last_gnt=B, so A wins the first tie.
  - Wait counter 0.
  - SRST mid-transaction aborts immediately with no done or err pulse.
- State IDLE:
  - If no request, stay.
  - If exactly one req is high, that master wins.
  - If both are high, the master not equal to last_gnt wins.
  - On a win, latch rw, addr, wdata into internal regs, set gnt_x, go to REQ.
- State REQ (1 cycle):
  - mem_ar=1; mem_addr and mem_wdata come from the latches.
  - Owner A: mem_rw_a=rw, mem_snoop_b=1, mem_rw_b=0, mem_snoop_a=0.
  - Owner B: the mirror image.
  - Go to WAIT and clear the counter.
- State WAIT:
  - Memory outputs are held as in REQ; the counter increments each cycle.
  - mem_dr is ignored in the first WAIT cycle, because the memory's DR may still be high from the previous access.
  - From the second WAIT cycle on, mem_dr=1 completes the access:
    - on a read, register rdata<=mem_rdata;
    - on a write, rdata is unchanged;
    - go to DONE.
  - If the counter reaches TIMEOUT with no DR: set the err flag and go to DONE.
  - If DR and timeout occur in the same cycle, DR wins and there is no error.
- State DONE (1 cycle):
  - mem_ar=0 and all mem_rw/snoop outputs=0.
  - done_x=1 for the owner; err=1 if flagged.
  - last_gnt<=owner, gnt_x<=0, go to IDLE.
- Requester rules:
  - The requester must drop req in the cycle after done_x.
  - A req still high in IDLE is a new request.
  - The arbiter ignores req changes outside IDLE.
- Minimum transaction is 5 cycles (IDLE, REQ, WAIT, WAIT, DONE).
- Back-to-back requests from both masters alternate A, B, A, ...
- gnt_a and gnt_b are never both high.

Optional Feature:
- Macro: ARB_FIXED_PRIO_EN.
- Defined: A always wins a tie, and last_gnt is unused; B can be starved.
- Undefined: round-robin as described above.

Test Plan:
- Reset, then A read addr=0x001205, memory returns 0x00000005 with DR in WAIT cycle 2 -> mem_ar high 3 cycles, mem_rw_a=1, mem_snoop_b=1, done_a pulse with rdata=0x00000005, gnt_b=0 throughout.
- B write addr=0x00400A, wdata=0xDEADBEEF -> mem_rw_b=0, mem_snoop_a=1, mem_wdata=0xDEADBEEF; done_b pulse; rdata unchanged.
- req_a and req_b raised together and kept asserted for 4 transactions -> grant order A, B, A, B; with ARB_FIXED_PRIO_EN -> A, A, A, A.
- mem_dr held high constantly -> first WAIT cycle ignored, completion in WAIT cycle 2, no err.
- mem_dr never asserted -> after 15 WAIT cycles, done_a=1 and err=1 in the same cycle, then the FSM returns to IDLE.
- SRST pulsed during WAIT -> next cycle all outputs 0, no done pulse, next tie granted to A.

Source files
------------

// File: rtl/snoop_bus_arbiter_if.sv
// Bus bundle between caches A/B, the snoop_bus_arbiter and the shared main memory.
// slave = arbiter view; master = requester/memory-model view.
interface snoop_bus_arbiter_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 32
);
  logic              req_a;
  logic              rw_a;
  logic [ADDR_W-1:0] addr_a;
  logic [DATA_W-1:0] wdata_a;
  logic              req_b;
  logic              rw_b;
  logic [ADDR_W-1:0] addr_b;
  logic [DATA_W-1:0] wdata_b;
  logic              gnt_a;
  logic              gnt_b;
  logic              done_a;
  logic              done_b;
  logic [DATA_W-1:0] rdata;
  logic              err;
  logic              mem_ar;
  logic              mem_rw_a;
  logic              mem_rw_b;
  logic              mem_snoop_a;
  logic              mem_snoop_b;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_dr;

  modport slave (
    input  req_a, rw_a, addr_a, wdata_a,
    input  req_b, rw_b, addr_b, wdata_b,
    input  mem_rdata, mem_dr,
    output gnt_a, gnt_b, done_a, done_b, rdata, err,
    output mem_ar, mem_rw_a, mem_rw_b, mem_snoop_a, mem_snoop_b,
    output mem_addr, mem_wdata
  );

  modport master (
    output req_a, rw_a, addr_a, wdata_a,
    output req_b, rw_b, addr_b, wdata_b,
    output mem_rdata, mem_dr,
    input  gnt_a, gnt_b, done_a, done_b, rdata, err,
    input  mem_ar, mem_rw_a, mem_rw_b, mem_snoop_a, mem_snoop_b,
    input  mem_addr, mem_wdata
  );
endinterface

// File: rtl/snoop_bus_arbiter.sv
// Two-master (cache A/B) arbiter in front of shared memory with snooper marking and WAIT timeout.
// Optional: define ARB_FIXED_PRIO_EN for fixed A-over-B priority instead of round-robin.
module snoop_bus_arbiter #(
  parameter int ADDR_W  = 24,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                  SCLK,
  input  logic                  SRST,
  snoop_bus_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } state_t;

  localparam logic [3:0] TMO_LAST = 4'(TIMEOUT - 1);

  state_t            state, state_nx;
  logic              gnt_a_q, gnt_b_q;
  logic              rw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [3:0]        cnt_q;
  logic              err_q;
  logic              win_a, win_b;
  logic              complete, timeout;
  logic              active;

`ifndef ARB_FIXED_PRIO_EN
  logic              last_gnt_b_q;
`endif

  always_ff @(posedge SCLK) begin
    if (SRST) state <= ST_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    win_a    = 1'b0;
    win_b    = 1'b0;
    complete = 1'b0;
    timeout  = 1'b0;
    case (state)
      ST_IDLE: begin
`ifdef ARB_FIXED_PRIO_EN
        win_a = bus.req_a;
        win_b = bus.req_b & ~bus.req_a;
`else
        win_a = bus.req_a & (~bus.req_b | last_gnt_b_q);
        win_b = bus.req_b & (~bus.req_a | ~last_gnt_b_q);
`endif
        if (win_a || win_b) state_nx = ST_REQ;
      end
      ST_REQ: state_nx = ST_WAIT;
      ST_WAIT: begin
        // DR in the first WAIT cycle (cnt==0) may be stale from the previous access
        if (cnt_q != '0 && bus.mem_dr) begin
          complete = 1'b1;
          state_nx = ST_DONE;
        end else if (cnt_q == TMO_LAST) begin
          timeout  = 1'b1;
          state_nx = ST_DONE;
        end
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge SCLK) begin
    if (SRST) begin
      gnt_a_q      <= 1'b0;
      gnt_b_q      <= 1'b0;
      rw_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
      last_gnt_b_q <= 1'b1;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (win_a) begin
            rw_q    <= bus.rw_a;
            addr_q  <= bus.addr_a;
            wdata_q <= bus.wdata_a;
          end else if (win_b) begin
            rw_q    <= bus.rw_b;
            addr_q  <= bus.addr_b;
            wdata_q <= bus.wdata_b;
          end
          gnt_a_q <= win_a;
          gnt_b_q <= win_b;
          err_q   <= 1'b0;
        end
        ST_REQ: cnt_q <= '0;
        ST_WAIT: begin
          if (complete) begin
            if (rw_q) rdata_q <= bus.mem_rdata;
          end else if (timeout) begin
            err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        ST_DONE: begin
`ifndef ARB_FIXED_PRIO_EN
          last_gnt_b_q <= gnt_b_q;
`endif
          gnt_a_q <= 1'b0;
          gnt_b_q <= 1'b0;
          err_q   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    active          = (state == ST_REQ) || (state == ST_WAIT);
    bus.gnt_a       = gnt_a_q;
    bus.gnt_b       = gnt_b_q;
    bus.rdata       = rdata_q;
    bus.mem_addr    = addr_q;
    bus.mem_wdata   = wdata_q;
    bus.mem_ar      = active;
    bus.mem_rw_a    = active & gnt_a_q & rw_q;
    bus.mem_rw_b    = active & gnt_b_q & rw_q;
    bus.mem_snoop_a = active & gnt_b_q;
    bus.mem_snoop_b = active & gnt_a_q;
    bus.done_a      = (state == ST_DONE) & gnt_a_q;
    bus.done_b      = (state == ST_DONE) & gnt_b_q;
    bus.err         = (state == ST_DONE) & err_q;
  end

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Directed, table-driven bench for snoop_bus_arbiter: a memory responder per vector plus reset/abort sequences.
module tb_snoop_bus_arbiter;

  localparam int ADDR_W = 24;
  localparam int DATA_W = 32;
  localparam int DR_NEVER  = 0;
  localparam int DR_ALWAYS = 255;

  logic SCLK = 1'b0;
  logic SRST = 1'b1;
  int   checks = 0;
  int   failures = 0;

  snoop_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  snoop_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(15)) dut (
    .SCLK (SCLK),
    .SRST (SRST),
    .bus  (bus.slave)
  );

  always #5 SCLK = ~SCLK;

  typedef struct {
    logic              req_a, req_b, rw_a, rw_b;
    logic [ADDR_W-1:0] addr_a, addr_b;
    logic [DATA_W-1:0] wdata_a, wdata_b, mrd;
    int                dr_at;        // WAIT cycle carrying DR, or DR_NEVER / DR_ALWAYS
    logic              exp_b;        // round-robin owner (1=B)
    logic              exp_b_fixed;  // fixed-priority owner
    logic [DATA_W-1:0] exp_rdata;
    logic              exp_err;
    int                exp_ar;       // cycles mem_ar is high
  } vec_t;

  localparam int NV = 9;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    bus.req_a = v.req_a;  bus.rw_a = v.rw_a;  bus.addr_a = v.addr_a;  bus.wdata_a = v.wdata_a;
    bus.req_b = v.req_b;  bus.rw_b = v.rw_b;  bus.addr_b = v.addr_b;  bus.wdata_b = v.wdata_b;
    bus.mem_rdata = v.mrd;
  endtask

  function automatic logic [9:0] ctl_bits();
    return {bus.gnt_a, bus.gnt_b, bus.done_a, bus.done_b, bus.err, bus.mem_ar,
            bus.mem_rw_a, bus.mem_rw_b, bus.mem_snoop_a, bus.mem_snoop_b};
  endfunction

  initial begin
    vec_t idle_v;
    logic eb;
    int   ar_cnt, cyc, bad_gnt;
    bit   seen_a, seen_b, seen_done, got;
    logic c_rw_a, c_rw_b, c_sn_a, c_sn_b, d_a, d_b, d_err;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata, d_rdata;

    idle_v = '{1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0, '0, DR_NEVER, 1'b0, 1'b0, '0, 1'b0, 0};
    //         ra    rb    rwa   rwb   addr_a     addr_b     wdata_a       wdata_b       mrd           dr         b     bfix  rdata         err   ar
    vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 24'h001205, 24'h0,     32'h0,        32'h0,        32'h00000005, 2,         1'b0, 1'b0, 32'h00000005, 1'b0, 3};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 24'h0,      24'h00400A, 32'h0,        32'hDEADBEEF, 32'h99999999, 3,         1'b1, 1'b1, 32'h00000005, 1'b0, 4};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 24'h000100, 24'h000200, 32'h11111111, 32'h22222222, 32'h77777777, 2,         1'b0, 1'b0, 32'h00000005, 1'b0, 3};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 24'h000100, 24'h000200, 32'h11111111, 32'h22222222, 32'h77777777, 2,         1'b1, 1'b0, 32'h00000005, 1'b0, 3};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 24'h000100, 24'h000200, 32'h11111111, 32'h22222222, 32'h77777777, 2,         1'b0, 1'b0, 32'h00000005, 1'b0, 3};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 24'h000100, 24'h000200, 32'h11111111, 32'h22222222, 32'h77777777, 2,         1'b1, 1'b0, 32'h00000005, 1'b0, 3};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 24'h00ABCD, 24'h0,     32'h0,        32'h0,        32'hCAFEF00D, DR_ALWAYS, 1'b0, 1'b0, 32'hCAFEF00D, 1'b0, 3};
    vecs[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 24'h003300, 24'h0,     32'h0,        32'h0,        32'h12345678, DR_NEVER,  1'b0, 1'b0, 32'hCAFEF00D, 1'b1, 16};
    vecs[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 24'h00FF00, 24'h0,     32'h0,        32'h0,        32'h0BADCAFE, 15,        1'b0, 1'b0, 32'h0BADCAFE, 1'b0, 16};

    apply(idle_v);
    bus.mem_dr = 1'b0;
    repeat (3) @(posedge SCLK);
    #1;
    check("reset_ctl", 64'(ctl_bits()), 64'h0);
    check("reset_rdata", 64'(bus.rdata), 64'h0);
    check("reset_addr", 64'({bus.mem_addr, bus.mem_wdata}), 64'h0);
    SRST = 1'b0;

    apply(vecs[0]);
    for (int i = 0; i < NV; i++) begin
`ifdef ARB_FIXED_PRIO_EN
      eb = vecs[i].exp_b_fixed;
`else
      eb = vecs[i].exp_b;
`endif
      ar_cnt = 0; cyc = 0; bad_gnt = 0;
      seen_a = 0; seen_b = 0; seen_done = 0;
      {c_rw_a, c_rw_b, c_sn_a, c_sn_b, d_a, d_b, d_err} = '0;
      c_addr = '0; c_wdata = '0; d_rdata = '0;
      while (!seen_done && cyc < 60) begin
        @(posedge SCLK); #1; cyc++;
        if (bus.gnt_a && bus.gnt_b) bad_gnt++;
        if (bus.gnt_a) seen_a = 1;
        if (bus.gnt_b) seen_b = 1;
        if (bus.mem_ar) begin
          ar_cnt++;
          if (ar_cnt == 1) begin
            {c_rw_a, c_rw_b, c_sn_a, c_sn_b} = {bus.mem_rw_a, bus.mem_rw_b, bus.mem_snoop_a, bus.mem_snoop_b};
            c_addr = bus.mem_addr; c_wdata = bus.mem_wdata;
          end
        end
        if (vecs[i].dr_at == DR_ALWAYS) bus.mem_dr = 1'b1;
        else bus.mem_dr = (vecs[i].dr_at != DR_NEVER) && bus.mem_ar && (ar_cnt == vecs[i].dr_at + 1);
        if (bus.done_a || bus.done_b) begin
          seen_done = 1;
          d_a = bus.done_a; d_b = bus.done_b; d_err = bus.err; d_rdata = bus.rdata;
          if (i + 1 < NV) begin
            apply(vecs[i+1]);
            bus.mem_dr = (vecs[i+1].dr_at == DR_ALWAYS);
          end else begin
            apply(idle_v);
            bus.mem_dr = 1'b0;
          end
        end
      end
      check($sformatf("v%0d_done_seen", i), 64'(seen_done), 64'h1);
      check($sformatf("v%0d_gnt_both", i), 64'(bad_gnt), 64'h0);
      check($sformatf("v%0d_gnt_a", i), 64'(seen_a), 64'(!eb));
      check($sformatf("v%0d_gnt_b", i), 64'(seen_b), 64'(eb));
      check($sformatf("v%0d_done_ab", i), 64'({d_a, d_b}), 64'({!eb, eb}));
      check($sformatf("v%0d_err", i), 64'(d_err), 64'(vecs[i].exp_err));
      check($sformatf("v%0d_rdata", i), 64'(d_rdata), 64'(vecs[i].exp_rdata));
      check($sformatf("v%0d_ar_cycles", i), 64'(ar_cnt), 64'(vecs[i].exp_ar));
      check($sformatf("v%0d_rw_snoop", i), 64'({c_rw_a, c_rw_b, c_sn_a, c_sn_b}),
            eb ? 64'({1'b0, vecs[i].rw_b, 1'b1, 1'b0}) : 64'({vecs[i].rw_a, 1'b0, 1'b0, 1'b1}));
      check($sformatf("v%0d_mem_addr", i), 64'(c_addr), eb ? 64'(vecs[i].addr_b) : 64'(vecs[i].addr_a));
      check($sformatf("v%0d_mem_wdata", i), 64'(c_wdata), eb ? 64'(vecs[i].wdata_b) : 64'(vecs[i].wdata_a));
    end

    // Abort an A read with SRST in WAIT; the last completed owner is A, so only a reset last_gnt grants A next.
    apply(vecs[7]);
    bus.mem_dr = 1'b0;
    ar_cnt = 0; cyc = 0; got = 0;
    while (ar_cnt < 3 && cyc < 20) begin
      @(posedge SCLK); #1; cyc++;
      if (bus.mem_ar) ar_cnt++;
      if (bus.done_a || bus.done_b) got = 1;
    end
    check("abort_reached_wait", 64'(ar_cnt), 64'd3);
    SRST = 1'b1;
    apply(idle_v);
    @(posedge SCLK); #1;
    check("abort_ctl_zero", 64'(ctl_bits()), 64'h0);
    check("abort_no_done_before", 64'(got), 64'h0);
    SRST = 1'b0;
    bus.req_a = 1'b1; bus.req_b = 1'b1;
    cyc = 0;
    while (!(bus.gnt_a || bus.gnt_b) && cyc < 10) begin
      @(posedge SCLK); #1; cyc++;
    end
    check("post_reset_tie_grant", 64'({bus.gnt_a, bus.gnt_b}), 64'b10);
    apply(idle_v);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
